// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore-style control FSM for a multicycle MIPS datapath. Decodes Op/Funct
//   for R-type (ADD/SUB/AND/XOR/NOP/BREAK), BEQ, BNE, LW, SW, LUI and J, holds
//   memory states for MEM_WAIT extra cycles, and parks in HALT or ILLEGAL.
//
// Ports
//   Clk, Reset_signal      clock (rising edge), async active-high reset
//   Op, Funct, ALU_zero    IR[31:26], IR[5:0], ALU zero flag
//   StateOut               registered copy of the state code (one cycle late)
//   PCWrite/PCWriteCond/BranchNe/PC_load   PC update controls
//   wr, IorD, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALU_sel,
//   IRWrite, RegWrite      datapath selects / enables
//   *_load, *_reset, RegReset              register loads and clears
//   Halted, Illegal        status of the two sticky states
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT     = 2,
    parameter int TRAP_ILLEGAL = 1,
    parameter int STATE_W      = 8
) (
    input  logic               Clk,
    input  logic               Reset_signal,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               ALU_zero,
    output logic [STATE_W-1:0] StateOut,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               PC_load,
    output logic               wr,
    output logic               IorD,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [2:0]         ALU_sel,
    output logic               A_load,
    output logic               B_load,
    output logic               MDR_load,
    output logic               ALUOut_load,
    output logic               IR_load,
    output logic               RegReset,
    output logic               A_reset,
    output logic               B_reset,
    output logic               MDR_reset,
    output logic               ALUOut_reset,
    output logic               IR_reset,
    output logic               Halted,
    output logic               Illegal
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_LW_MEM   = 4'd4,
        S_LW_WB    = 4'd5,
        S_SW_MEM   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_LUI_WB   = 4'd11,
        S_HALT     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_LUI  = 3'b111;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state, next_state, bad_op_state;
    logic [3:0] cnt;
    logic       last;       // final cycle of a memory state
    logic       mem_entry;

    assign last         = (cnt == 4'd0);
    assign bad_op_state = (TRAP_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
    // Self-loops while waiting are not entries; only a real transition reloads.
    assign mem_entry    = (next_state != state) &&
                          (next_state == S_FETCH || next_state == S_LW_MEM ||
                           next_state == S_SW_MEM);

    always_ff @(posedge Clk or posedge Reset_signal) begin
        if (Reset_signal) begin
            state    <= S_RESET;
            cnt      <= 4'd0;
            StateOut <= '0;
        end else begin
            state    <= next_state;
            StateOut <= STATE_W'(state);
            if (mem_entry)
                cnt <= WAIT_INIT;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  if (last) next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    6'h00: begin
                        case (Funct)
                            6'h00:                      next_state = S_FETCH;
                            6'h0d:                      next_state = S_HALT;
                            6'h20, 6'h22, 6'h24, 6'h26: next_state = S_R_EXEC;
                            default:                    next_state = bad_op_state;
                        endcase
                    end
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h23, 6'h2b: next_state = S_MEM_ADDR;
                    6'h0f:        next_state = S_LUI_WB;
                    6'h02:        next_state = S_JUMP;
                    default:      next_state = bad_op_state;
                endcase
            end
            S_R_EXEC:   next_state = S_R_WB;
            S_R_WB:     next_state = S_FETCH;
            S_MEM_ADDR: next_state = (Op == 6'h23) ? S_LW_MEM : S_SW_MEM;
            S_LW_MEM:   if (last) next_state = S_LW_WB;
            S_LW_WB:    next_state = S_FETCH;
            S_SW_MEM:   if (last) next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_LUI_WB:   next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            S_ILLEGAL:  next_state = S_ILLEGAL;
            default:    next_state = S_RESET;
        endcase
    end

    // Output decode (state plus the wait counter; BranchNe also looks at Op)
    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        BranchNe     = 1'b0;
        wr           = 1'b0;
        IorD         = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        ALUSrcA      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALU_sel      = ALU_PASS;
        A_load       = 1'b0;
        B_load       = 1'b0;
        MDR_load     = 1'b0;
        ALUOut_load  = 1'b0;
        IR_load      = 1'b0;
        RegReset     = 1'b0;
        A_reset      = 1'b0;
        B_reset      = 1'b0;
        MDR_reset    = 1'b0;
        ALUOut_reset = 1'b0;
        IR_reset     = 1'b0;
        Halted       = 1'b0;
        Illegal      = 1'b0;
        case (state)
            S_RESET: begin
                RegReset     = 1'b1;
                A_reset      = 1'b1;
                B_reset      = 1'b1;
                MDR_reset    = 1'b1;
                ALUOut_reset = 1'b1;
                IR_reset     = 1'b1;
            end
            S_FETCH: begin
                // Memory read is held for the whole fetch; capture and PC+4
                // happen only once the data is valid.
                if (last) begin
                    IRWrite  = 1'b1;
                    IR_load  = 1'b1;
                    MDR_load = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcB  = 2'b01;
                    ALU_sel  = ALU_ADD;
                end
            end
            S_DECODE: begin
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUOut_load = 1'b1;
                ALUSrcB     = 2'b11;
                ALU_sel     = ALU_ADD;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUOut_load = 1'b1;
                case (Funct)
                    6'h22:   ALU_sel = ALU_SUB;
                    6'h24:   ALU_sel = ALU_AND;
                    6'h26:   ALU_sel = ALU_XOR;
                    default: ALU_sel = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_sel     = ALU_ADD;
                ALUOut_load = 1'b1;
            end
            S_LW_MEM: begin
                IorD     = 1'b1;
                MDR_load = last;
            end
            S_LW_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_SW_MEM: begin
                IorD = 1'b1;
                wr   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_sel     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (Op == 6'h05);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_LUI_WB: begin
                // ALU result goes straight to the register write port.
                ALUSrcB  = 2'b10;
                ALU_sel  = ALU_LUI;
                RegWrite = 1'b1;
            end
            S_HALT:    Halted  = 1'b1;
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

    assign PC_load = PCWrite | (PCWriteCond & (ALU_zero ^ BranchNe));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Three instances share clock, reset and
// instruction inputs: [0] MEM_WAIT=2 trap on, [1] MEM_WAIT=0 trap off,
// [2] MEM_WAIT=3 trap on.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [7:0] StateOut;
        logic PCWrite, PCWriteCond, BranchNe, PC_load, wr, IorD, MemtoReg, RegDst;
        logic ALUSrcA, IRWrite, RegWrite;
        logic [1:0] ALUSrcB, PCSource;
        logic [2:0] ALU_sel;
        logic A_load, B_load, MDR_load, ALUOut_load, IR_load;
        logic RegReset, A_reset, B_reset, MDR_reset, ALUOut_reset, IR_reset;
        logic Halted, Illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op, funct;
        logic       zero;
        int         st;     // state expected this cycle
        logic       pcw, rw, rd, pcl;
        logic [2:0] alu;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset_signal = 1'b1;
    logic [5:0] Op = 6'h00, Funct = 6'h00;
    logic       ALU_zero = 1'b0;
    ctl_t       o [3];

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_multicycle_ctrl #(
            .MEM_WAIT    (g == 0 ? 2 : (g == 1 ? 0 : 3)),
            .TRAP_ILLEGAL(g == 1 ? 0 : 1),
            .STATE_W     (8)
        ) u_dut (
            .Clk(Clk), .Reset_signal(Reset_signal), .Op(Op), .Funct(Funct), .ALU_zero(ALU_zero),
            .StateOut(o[g].StateOut), .PCWrite(o[g].PCWrite), .PCWriteCond(o[g].PCWriteCond),
            .BranchNe(o[g].BranchNe), .PC_load(o[g].PC_load), .wr(o[g].wr), .IorD(o[g].IorD),
            .MemtoReg(o[g].MemtoReg), .RegDst(o[g].RegDst), .ALUSrcA(o[g].ALUSrcA),
            .IRWrite(o[g].IRWrite), .RegWrite(o[g].RegWrite), .ALUSrcB(o[g].ALUSrcB),
            .PCSource(o[g].PCSource), .ALU_sel(o[g].ALU_sel), .A_load(o[g].A_load),
            .B_load(o[g].B_load), .MDR_load(o[g].MDR_load), .ALUOut_load(o[g].ALUOut_load),
            .IR_load(o[g].IR_load), .RegReset(o[g].RegReset), .A_reset(o[g].A_reset),
            .B_reset(o[g].B_reset), .MDR_reset(o[g].MDR_reset), .ALUOut_reset(o[g].ALUOut_reset),
            .IR_reset(o[g].IR_reset), .Halted(o[g].Halted), .Illegal(o[g].Illegal)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int resets(input ctl_t c);
        return int'({c.RegReset, c.A_reset, c.B_reset, c.MDR_reset, c.ALUOut_reset, c.IR_reset});
    endfunction

    function automatic int enables(input ctl_t c);
        return int'({c.A_load, c.B_load, c.MDR_load, c.ALUOut_load, c.IR_load, c.IRWrite,
                     c.RegWrite, c.PCWrite, c.PCWriteCond, c.PC_load, c.wr});
    endfunction

    function automatic int selects(input ctl_t c);
        return int'({c.IorD, c.MemtoReg, c.RegDst, c.ALUSrcA, c.ALUSrcB, c.PCSource, c.ALU_sel});
    endfunction

    // Leaves all instances in RESET at a falling edge with reset released.
    task automatic do_reset();
        Reset_signal = 1'b1;
        @(negedge Clk);
        Reset_signal = 1'b0;
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] f, input logic z, input int st,
                       input logic pcw, input logic rw, input logic rd, input logic pcl,
                       input logic [2:0] alu);
        vec_t v;
        v.op = op; v.funct = f; v.zero = z; v.st = st;
        v.pcw = pcw; v.rw = rw; v.rd = rd; v.pcl = pcl; v.alu = alu;
        tbl.push_back(v);
    endtask

    // Three fetch cycles (MEM_WAIT=2) then DECODE.
    task automatic add_fd(input logic [5:0] op, input logic [5:0] f, input logic z);
        add(op, f, z, 1, 0, 0, 0, 0, 3'd0);
        add(op, f, z, 1, 0, 0, 0, 0, 3'd0);
        add(op, f, z, 1, 1, 0, 0, 1, 3'd1);
        add(op, f, z, 2, 0, 0, 0, 0, 3'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, k, hk, ik, wbk[3], iorc[3], mdrc[3], mk[3], wrc, wrf, irk;
        string nm;

        // ---------------- reset state ----------------
        @(negedge Clk);
        chk("rst_state", int'(o[0].StateOut), 0);
        chk("rst_resets", resets(o[0]), 6'h3f);
        chk("rst_enables", enables(o[0]), 0);
        chk("rst_selects", selects(o[0]), 0);

        // ---------------- table-driven sequences on instance 0 ----------------
        add_fd(6'h00, 6'h20, 0);                       // ADD
        add(6'h00, 6'h20, 0, 7, 0, 0, 0, 0, 3'd1);
        add(6'h00, 6'h20, 0, 8, 0, 1, 1, 0, 3'd0);
        add_fd(6'h00, 6'h22, 0);                       // SUB
        add(6'h00, 6'h22, 0, 7, 0, 0, 0, 0, 3'd2);
        add(6'h00, 6'h22, 0, 8, 0, 1, 1, 0, 3'd0);
        add_fd(6'h00, 6'h26, 0);                       // XOR
        add(6'h00, 6'h26, 0, 7, 0, 0, 0, 0, 3'd6);
        add(6'h00, 6'h26, 0, 8, 0, 1, 1, 0, 3'd0);
        add_fd(6'h04, 6'h00, 1);                       // BEQ taken
        add(6'h04, 6'h00, 1, 9, 0, 0, 0, 1, 3'd2);
        add_fd(6'h04, 6'h00, 0);                       // BEQ not taken
        add(6'h04, 6'h00, 0, 9, 0, 0, 0, 0, 3'd2);
        add_fd(6'h05, 6'h00, 1);                       // BNE, zero -> not taken
        add(6'h05, 6'h00, 1, 9, 0, 0, 0, 0, 3'd2);
        add_fd(6'h05, 6'h00, 0);                       // BNE, nonzero -> taken
        add(6'h05, 6'h00, 0, 9, 0, 0, 0, 1, 3'd2);
        add_fd(6'h0f, 6'h00, 0);                       // LUI
        add(6'h0f, 6'h00, 0, 11, 0, 1, 0, 0, 3'd7);
        add_fd(6'h02, 6'h00, 0);                       // J
        add(6'h02, 6'h00, 0, 10, 1, 0, 0, 1, 3'd0);

        do_reset();
        prev = 0;
        foreach (tbl[i]) begin
            Op = tbl[i].op; Funct = tbl[i].funct; ALU_zero = tbl[i].zero;
            @(negedge Clk);
            nm = $sformatf("v%0d", i);
            chk({nm, "_stateout"}, int'(o[0].StateOut), prev);
            chk({nm, "_pcwrite"},  int'(o[0].PCWrite),  int'(tbl[i].pcw));
            chk({nm, "_regwrite"}, int'(o[0].RegWrite), int'(tbl[i].rw));
            chk({nm, "_regdst"},   int'(o[0].RegDst),   int'(tbl[i].rd));
            chk({nm, "_pc_load"},  int'(o[0].PC_load),  int'(tbl[i].pcl));
            chk({nm, "_alu_sel"},  int'(o[0].ALU_sel),  int'(tbl[i].alu));
            prev = tbl[i].st;
        end

        // ---------------- HALT, sticky, async reset out of it ----------------
        do_reset();
        Op = 6'h00; Funct = 6'h0d;
        hk = -1;
        for (int c = 0; c < 20 && hk < 0; c++) begin
            @(negedge Clk);
            if (o[0].Halted) hk = c;
        end
        chk("halt_entry_cycle", hk, 4);
        @(negedge Clk);                                // StateOut catches up
        for (int c = 0; c < 20; c++) begin
            chk("halt_sticky_state", int'(o[0].StateOut), 12);
            chk("halt_sticky_flag", int'(o[0].Halted), 1);
            @(negedge Clk);
        end
        #2 Reset_signal = 1'b1;
        #1;
        chk("halt_rst_state", int'(o[0].StateOut), 0);
        chk("halt_rst_resets", resets(o[0]), 6'h3f);
        chk("halt_rst_halted", int'(o[0].Halted), 0);
        @(negedge Clk);
        Reset_signal = 1'b0;

        // ---------------- illegal op, trap on [0] and off [1] ----------------
        Op = 6'h3f; Funct = 6'h00;
        ik = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clk);
            if (o[0].Illegal && ik < 0) ik = c;
            chk("nontrap_illegal_low", int'(o[1].Illegal), 0);
            if (c == 1) chk("nontrap_decode", int'(o[1].StateOut), 1);
            if (c == 2) chk("nontrap_refetch", int'(o[1].StateOut), 2);
            if (c == 2) chk("nontrap_irwrite", int'(o[1].IRWrite), 1);
            if (c >= 4) chk("trap_illegal_sticky", int'(o[0].Illegal), 1);
        end
        chk("trap_entry_cycle", ik, 4);
        chk("trap_state", int'(o[0].StateOut), 13);

        // ---------------- LW latency, W=0 [1] and W=3 [2] ----------------
        do_reset();
        Op = 6'h23; Funct = 6'h00;
        for (int g = 0; g < 3; g++) begin wbk[g] = -1; iorc[g] = 0; mdrc[g] = 0; mk[g] = -1; end
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            for (int g = 1; g < 3; g++) begin
                if (o[g].MemtoReg && wbk[g] < 0) wbk[g] = c;
                if (wbk[g] < 0) begin
                    iorc[g] += int'(o[g].IorD);
                    if (o[g].MDR_load && o[g].IorD) begin mdrc[g]++; mk[g] = c; end
                end
            end
        end
        // Cycles from the first FETCH cycle to the LW_WB cycle: 2W+4.
        chk("lw_w0_latency", wbk[1], 4);
        chk("lw_w3_latency", wbk[2], 10);
        chk("lw_w0_mem_cycles", iorc[1], 1);
        chk("lw_w3_mem_cycles", iorc[2], 4);
        chk("lw_w0_mdr_pulses", mdrc[1], 1);
        chk("lw_w3_mdr_pulses", mdrc[2], 1);
        chk("lw_w0_mdr_final", mk[1], 3);
        chk("lw_w3_mdr_final", mk[2], 9);

        // ---------------- SW, W=3 [2] ----------------
        do_reset();
        Op = 6'h2b;
        wrc = 0; wrf = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge Clk);
            if (o[2].wr) begin
                wrc++;
                if (wrf < 0) wrf = c;
            end
        end
        chk("sw_w3_wr_cycles", wrc, 4);
        chk("sw_w3_wr_first", wrf, 6);

        // ---------------- reset mid LW_MEM on [0] ----------------
        do_reset();
        Op = 6'h23;
        for (int c = 0; c < 6; c++) @(negedge Clk);    // first LW_MEM cycle, cnt=2
        chk("midlw_in_mem", int'(o[0].IorD), 1);
        chk("midlw_mdr_idle", int'(o[0].MDR_load), 0);
        #2 Reset_signal = 1'b1;
        #1;
        chk("midlw_rst_state", int'(o[0].StateOut), 0);
        chk("midlw_rst_iord", int'(o[0].IorD), 0);
        chk("midlw_rst_wr", int'(o[0].wr), 0);
        chk("midlw_rst_mdr_load", int'(o[0].MDR_load), 0);
        chk("midlw_rst_mdr_reset", int'(o[0].MDR_reset), 1);
        @(negedge Clk);
        Reset_signal = 1'b0;
        irk = -1;
        for (int c = 0; c < 6 && irk < 0; c++) begin
            @(negedge Clk);
            if (o[0].IRWrite) irk = c;
        end
        chk("midlw_refetch_full_wait", irk, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
